// File: rtl/offnariscv_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Package  : offnariscv_pkg                                                   |
// | Purpose  : execution-unit identifiers and sizing helpers for commit logic   |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
package offnariscv_pkg;

  localparam int NUM_EXEC_UNITS = 3;
  localparam int UNIT_ID_W      = $clog2(NUM_EXEC_UNITS);

  typedef logic [UNIT_ID_W-1:0] unit_id_t;

  localparam unit_id_t UNIT_ALU = unit_id_t'(0);
  localparam unit_id_t UNIT_BRU = unit_id_t'(1);
  localparam unit_id_t UNIT_LSU = unit_id_t'(2);

  // One extra pointer bit distinguishes full from empty.
  function automatic int order_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/order_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : order_fifo                                                       |
// | Purpose  : synchronous FIFO of unit indices with clear and occupancy count  |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module order_fifo
  import offnariscv_pkg::*;
#(
  parameter  int WIDTH = 2,
  parameter  int DEPTH = 8,
  localparam int CNT_W = order_cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int IDX_W = CNT_W - 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0] wr_q, wr_d;
  logic [CNT_W-1:0] rd_q, rd_d;
  logic             w_push;
  logic             w_pop;

  assign full_o  = (wr_q[CNT_W-1] != rd_q[CNT_W-1]) && (wr_q[IDX_W-1:0] == rd_q[IDX_W-1:0]);
  assign empty_o = (wr_q == rd_q);
  assign count_o = wr_q - rd_q;
  assign dout_o  = mem_q[rd_q[IDX_W-1:0]];

  // A clear wins over any concurrent push or pop.
  assign w_push = push_i & ~full_o & ~clear_i;
  assign w_pop  = pop_i & ~empty_o & ~clear_i;

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (clear_i) begin
      rd_d = wr_q;
    end else begin
      if (w_push) wr_d = wr_q + CNT_W'(1);
      if (w_pop)  rd_d = rd_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_q[IDX_W-1:0]] <= din_i;
  end

endmodule
`default_nettype wire

// File: rtl/commit_merger.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : commit_merger                                                    |
// | Purpose  : in-order writeback merger of N execution-unit result streams     |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module commit_merger
  import offnariscv_pkg::*;
#(
  parameter  int NUM_UNITS   = NUM_EXEC_UNITS,
  parameter  int PAYLOAD_W   = 128,
  parameter  int ORDER_DEPTH = 8,
  localparam int UNIT_W      = $clog2(NUM_UNITS),
  localparam int CNT_W       = order_cnt_w(ORDER_DEPTH)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           disp_tvalid,
  output logic                           disp_tready,
  input  logic [UNIT_W-1:0]              disp_tunit,
  input  logic [NUM_UNITS-1:0]           ex_tvalid,
  output logic [NUM_UNITS-1:0]           ex_tready,
  input  logic [NUM_UNITS*PAYLOAD_W-1:0] ex_tdata,
  input  logic [NUM_UNITS-1:0]           ex_tredirect,
  output logic                           wb_tvalid,
  input  logic                           wb_tready,
  output logic [PAYLOAD_W-1:0]           wb_tdata,
  output logic [UNIT_W-1:0]              wb_tunit,
  output logic                           wb_tredirect,
  output logic                           flush,
  output logic [CNT_W-1:0]               occupancy
);

  logic [UNIT_W-1:0]    w_head;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_head_ok;
  logic                 w_accept;
  logic [NUM_UNITS-1:0] w_sel;
  logic [PAYLOAD_W-1:0] w_head_data;
  logic                 w_head_redirect;

  logic                 wb_tvalid_q, wb_tvalid_d;
  logic [PAYLOAD_W-1:0] wb_tdata_q, wb_tdata_d;
  logic [UNIT_W-1:0]    wb_tunit_q, wb_tunit_d;
  logic                 wb_tredirect_q, wb_tredirect_d;
  logic                 flush_q, flush_d;

  order_fifo #(
    .WIDTH (UNIT_W),
    .DEPTH (ORDER_DEPTH)
  ) u_order_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (disp_tvalid & disp_tready),
    .pop_i   (w_accept),
    .clear_i (flush_q),
    .din_i   (disp_tunit),
    .dout_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (occupancy)
  );

  assign disp_tready = ~w_full & ~flush_q;

  generate
    for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_head_sel
      assign w_sel[gi] = (w_head == UNIT_W'(gi));
    end
  endgenerate

  // Ready is offered to the head unit whenever the output slot can take a result.
  assign w_head_ok = ~w_empty & ~flush_q & (~wb_tvalid_q | wb_tready);
  assign ex_tready = w_sel & {NUM_UNITS{w_head_ok}};
  assign w_accept  = |(ex_tready & ex_tvalid);

  always_comb begin
    w_head_data     = '0;
    w_head_redirect = 1'b0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (w_sel[i]) begin
        w_head_data     = ex_tdata[i*PAYLOAD_W +: PAYLOAD_W];
        w_head_redirect = ex_tredirect[i];
      end
    end
  end

  always_comb begin
    wb_tvalid_d    = wb_tvalid_q;
    wb_tdata_d     = wb_tdata_q;
    wb_tunit_d     = wb_tunit_q;
    wb_tredirect_d = wb_tredirect_q;
    if (w_accept) begin
      wb_tvalid_d    = 1'b1;
      wb_tdata_d     = w_head_data;
      wb_tunit_d     = w_head;
      wb_tredirect_d = w_head_redirect;
    end else if (wb_tready) begin
      wb_tvalid_d    = 1'b0;
    end
    flush_d = w_accept & w_head_redirect;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_tvalid_q    <= 1'b0;
      wb_tdata_q     <= '0;
      wb_tunit_q     <= '0;
      wb_tredirect_q <= 1'b0;
      flush_q        <= 1'b0;
    end else begin
      wb_tvalid_q    <= wb_tvalid_d;
      wb_tdata_q     <= wb_tdata_d;
      wb_tunit_q     <= wb_tunit_d;
      wb_tredirect_q <= wb_tredirect_d;
      flush_q        <= flush_d;
    end
  end

  assign wb_tvalid    = wb_tvalid_q;
  assign wb_tdata     = wb_tdata_q;
  assign wb_tunit     = wb_tunit_q;
  assign wb_tredirect = wb_tredirect_q;
  assign flush        = flush_q;

  a_legal_unit: assert property (@(posedge clk) disable iff (!rst)
    disp_tvalid |-> (int'(disp_tunit) < NUM_UNITS));

endmodule
`default_nettype wire
